clk_monitor: RTL and testbench
==============================

// Module: clk_monitor
// PURPOSE
//  System-clock-domain companion to the divided-clock generator. Samples the generated
//  clock, emits single-cycle rise/fall strobes, and measures each half-period in system_clk cycles.
//  Declares lock once the measurements are stable, and flags a lost or mis-timed clock.
//  Sits beside the pipeline clock source and feeds status/debug logic.
// PARAMETERS
//  SYNC_STAGES  2    synchronizer flops on clk_in (>=2)
//  CNT_W        8    width of half-period counter/measurement
//  EXP_HALF     2    expected half-period, system_clk cycles
//  TOL          0    allowed |measured-EXP_HALF| deviation
//  LOCK_CNT     4    consecutive in-tolerance half-periods required for lock
//  TIMEOUT      16   system_clk cycles without an edge => clock lost (< 2**CNT_W)
// PORTS
//  system_clk   in   1      monitor clock
//  reset        in   1      asynchronous, active-high
//  clk_in       in   1      monitored (divided) clock, treated as asynchronous
//  rise_pulse   out  1      one-cycle strobe per synchronized rising edge
//  fall_pulse   out  1      one-cycle strobe per synchronized falling edge
//  half_period  out  CNT_W  last measured half-period, cycles
//  period_valid out  1      one-cycle strobe: half_period just updated
//  locked       out  1      clock within tolerance for >= LOCK_CNT half-periods
//  clk_lost     out  1      no edge for TIMEOUT cycles
//  err_count    out  8      saturating count of tolerance/timeout errors
// BEHAVIOUR
//  Reset: all outputs 0, sync chain 0, hcnt 0, good count 0, state IDLE; async assert, sync use.
//  Sync: clk_in -> SYNC_STAGES flops -> prev flop; edge = last stage != prev.
//  Strobes registered: pulse high exactly 1 cycle, SYNC_STAGES+1 system_clk edges after
//   first edge sampling the new clk_in level. Never both strobes in one cycle.
//  hcnt: on edge cycle meas = hcnt+1 (saturating at 2**CNT_W-1), hcnt <= 0; else hcnt+1 saturating.
//  ok = (meas >= EXP_HALF-TOL) && (meas <= EXP_HALF+TOL); compare in CNT_W+1 bits, no underflow.
//  FSM states IDLE, ACQUIRE, LOCKED, LOST:
//   IDLE: edge -> ACQUIRE, meas discarded (no period_valid); TIMEOUT -> LOST.
//   ACQUIRE: edge: half_period<=meas, period_valid=1; ok -> good+1, good==LOCK_CNT -> LOCKED;
//    !ok -> good<=0, err_count+1. TIMEOUT -> LOST.
//   LOCKED: edge: update half_period/period_valid; !ok -> ACQUIRE, good<=0, err+1.
//    TIMEOUT -> LOST.
//   LOST: edge -> ACQUIRE, good<=0, meas discarded. No further err increments while in LOST.
//  TIMEOUT event = no edge this cycle and hcnt == TIMEOUT-1 (TIMEOUT edge-free cycles).
//  Entering LOST from any state: err_count+1 once, locked<=0.
//  Edge and timeout in same cycle: edge wins, no timeout.
//  locked = (state==LOCKED), clk_lost = (state==LOST); both registered.
//  These update on the cycle after the transition.
//  err_count saturates at 255, never wraps; cleared only by reset.
//  Generator held in reset (clk_in stuck low) -> LOST after TIMEOUT; recovery is automatic.
// TESTING (defaults)
//  clk_in toggles every 2 cycles from reset release -> rise/fall strobes alternate 2 cycles apart.
//   Also: half_period=2, locked=1 the cycle after the 5th edge strobe, err_count=0.
//  Locked, then clk_in held low -> 16 edge-free cycles later clk_lost=1, locked=0, err_count=1.
//   Resume toggling -> clk_lost=0 on first edge, relock after 4 more good edges.
//  Locked, one half-period of 3 -> period_valid with half_period=3, locked=0, err_count+1.
//   Relocks after 4 good halves.
//  Assert reset mid-LOCKED between system_clk edges -> all outputs 0 immediately, then IDLE.
//  No clk_in edges after reset -> clk_lost=1 after 16 cycles, err_count=1, no period_valid ever.
//  Alternate 3/2 half-periods for 600 edges -> locked never set, err_count stops at 255.

Source files
------------

// File: rtl/clk_monitor.sv
// Clock monitor: synchronizes a generated clock into system_clk, strobes its
// edges, measures half-periods and tracks lock / loss of the monitored clock.
module clk_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned EXP_HALF    = 2,
  parameter int unsigned TOL         = 0,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic             system_clk,
  input  logic             reset,
  input  logic             clk_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             locked,
  output logic             clk_lost,
  output logic [7:0]       err_count
);

  localparam int unsigned CW1    = CNT_W + 1;
  localparam int unsigned GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int unsigned LO_LIM = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
  localparam int unsigned HI_LIM = EXP_HALF + TOL;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       hcnt_q;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic                   rise_q, fall_q, pv_q, pv_d, locked_q, lost_q;
  logic [CNT_W-1:0]       hp_q, hp_d;
  logic [7:0]             err_q;
  logic                   err_inc_c;

  logic                   lvl_c, edge_c, timeout_c, ok_c;
  logic [CW1-1:0]         inc_c;
  logic [CNT_W-1:0]       meas_c;

  // Edge detection and saturating half-period measurement
  always_comb begin
    lvl_c     = sync_q[SYNC_STAGES-1];
    edge_c    = lvl_c ^ prev_q;
    inc_c     = {1'b0, hcnt_q} + CW1'(1);
    meas_c    = inc_c[CNT_W] ? CNT_MAX : inc_c[CNT_W-1:0];
    ok_c      = ({1'b0, meas_c} >= CW1'(LO_LIM)) && ({1'b0, meas_c} <= CW1'(HI_LIM));
    timeout_c = !edge_c && (hcnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Next-state, lock counting and error events
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    err_inc_c = 1'b0;
    pv_d      = 1'b0;
    hp_d      = hp_q;
    case (state_q)
      IDLE: begin
        if (edge_c) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end else if (timeout_c) begin
          state_d   = LOST;
          err_inc_c = 1'b1;
        end
      end
      ACQUIRE: begin
        if (edge_c) begin
          pv_d = 1'b1;
          hp_d = meas_c;
          if (ok_c) begin
            if ((32'(good_q) + 32'd1) >= LOCK_CNT) begin
              state_d = LOCKED;
              good_d  = '0;
            end else begin
              good_d = good_q + GOOD_W'(1);
            end
          end else begin
            good_d    = '0;
            err_inc_c = 1'b1;
          end
        end else if (timeout_c) begin
          state_d   = LOST;
          good_d    = '0;
          err_inc_c = 1'b1;
        end
      end
      LOCKED: begin
        if (edge_c) begin
          pv_d = 1'b1;
          hp_d = meas_c;
          if (!ok_c) begin
            state_d   = ACQUIRE;
            good_d    = '0;
            err_inc_c = 1'b1;
          end
        end else if (timeout_c) begin
          state_d   = LOST;
          err_inc_c = 1'b1;
        end
      end
      LOST: begin
        if (edge_c) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Synchronizer, counters, FSM state and registered outputs
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      hcnt_q   <= '0;
      good_q   <= '0;
      state_q  <= IDLE;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pv_q     <= 1'b0;
      hp_q     <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], clk_in};
      prev_q   <= lvl_c;
      hcnt_q   <= edge_c ? '0 : meas_c;
      good_q   <= good_d;
      state_q  <= state_d;
      rise_q   <= edge_c && lvl_c;
      fall_q   <= edge_c && !lvl_c;
      pv_q     <= pv_d;
      hp_q     <= hp_d;
      locked_q <= (state_q == LOCKED);
      lost_q   <= (state_q == LOST);
      if (err_inc_c && (err_q != 8'hFF)) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign half_period  = hp_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign clk_lost     = lost_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: per-cycle vector table for lock-up, then
// hand-written sequences for loss, recovery, glitch, reset and error saturation.
module tb_clk_monitor;

  logic       system_clk;
  logic       reset;
  logic       clk_in;
  logic       rise_pulse, fall_pulse, period_valid, locked, clk_lost;
  logic [7:0] half_period;
  logic [7:0] err_count;

  int total = 0;
  int bad   = 0;

  clk_monitor dut (
    .system_clk  (system_clk),
    .reset       (reset),
    .clk_in      (clk_in),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .half_period (half_period),
    .period_valid(period_valid),
    .locked      (locked),
    .clk_lost    (clk_lost),
    .err_count   (err_count)
  );

  initial system_clk = 1'b0;
  always #5 system_clk = ~system_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       clk;
    logic       rise;
    logic       fall;
    logic       pv;
    logic [7:0] hp;
    logic       lck;
    logic       lost;
    logic [7:0] err;
  } vec_t;

  vec_t vt[20];

  // Bookkeeping updated on every sampled cycle
  int   cyc = 0;
  int   n_edges = 0;
  int   last_edge_cyc = 0;
  logic lk_prev = 1'b0, lost_prev = 1'b0, rise_prev = 1'b0, fall_prev = 1'b0;
  logic [7:0] err_prev = '0;
  int   pv_cnt = 0;
  logic lock_seen = 1'b0, wrap_seen = 1'b0, both_seen = 1'b0, dbl_seen = 1'b0;
  int   lock_rise_edges = 0, lock_rise_dly = 0, unlock_dly = 0;
  int   lost_fall_edges = 0, lost_fall_dly = 0;
  int   bad_hp = 0, bad_err = 0, bad_edge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
    cyc++;
    if (locked && !lk_prev) begin
      lock_rise_edges = n_edges;
      lock_rise_dly   = cyc - last_edge_cyc;
    end
    if (!locked && lk_prev) unlock_dly = cyc - last_edge_cyc;
    if (!clk_lost && lost_prev) begin
      lost_fall_edges = n_edges;
      lost_fall_dly   = cyc - last_edge_cyc;
    end
    if (rise_pulse || fall_pulse) begin
      n_edges++;
      last_edge_cyc = cyc;
    end
    if (period_valid) pv_cnt++;
    if (period_valid && half_period != 8'd2) begin
      bad_hp   = int'(half_period);
      bad_err  = int'(err_count);
      bad_edge = n_edges;
    end
    if (locked) lock_seen = 1'b1;
    if (err_count < err_prev) wrap_seen = 1'b1;
    if (rise_pulse && fall_pulse) both_seen = 1'b1;
    if ((rise_pulse && rise_prev) || (fall_pulse && fall_prev)) dbl_seen = 1'b1;
    lk_prev   = locked;
    lost_prev = clk_lost;
    rise_prev = rise_pulse;
    fall_prev = fall_pulse;
    err_prev  = err_count;
  endtask

  task automatic halfp(input int len);
    clk_in = ~clk_in;
    repeat (len) tick();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rise"}, 32'(rise_pulse), 32'd0);
    chk({nm, "_fall"}, 32'(fall_pulse), 32'd0);
    chk({nm, "_pv"},   32'(period_valid), 32'd0);
    chk({nm, "_hp"},   32'(half_period), 32'd0);
    chk({nm, "_lck"},  32'(locked), 32'd0);
    chk({nm, "_lost"}, 32'(clk_lost), 32'd0);
    chk({nm, "_err"},  32'(err_count), 32'd0);
  endtask

  initial begin
    int e0;

    // clk_in toggles every 2 cycles; the sync chain delays each change by 3 edges
    for (int n = 0; n < 20; n++) begin
      vt[n].clk  = 1'((n / 2) % 2);
      vt[n].rise = (n >= 4) && (n % 4 == 0);
      vt[n].fall = (n >= 6) && (n % 4 == 2);
      vt[n].pv   = (n >= 6) && (n % 2 == 0);
      vt[n].hp   = (n >= 6) ? 8'd2 : 8'd0;
      vt[n].lck  = (n >= 13);
      vt[n].lost = 1'b0;
      vt[n].err  = 8'd0;
    end

    reset  = 1'b1;
    clk_in = 1'b0;
    repeat (3) @(posedge system_clk);
    #1;
    chk_all_zero("reset");
    @(negedge system_clk);
    reset = 1'b0;

    // Lock-up from reset release
    for (int n = 0; n < 20; n++) begin
      clk_in = vt[n].clk;
      tick();
      chk($sformatf("v%0d_rise", n), 32'(rise_pulse),   32'(vt[n].rise));
      chk($sformatf("v%0d_fall", n), 32'(fall_pulse),   32'(vt[n].fall));
      chk($sformatf("v%0d_pv", n),   32'(period_valid), 32'(vt[n].pv));
      chk($sformatf("v%0d_hp", n),   32'(half_period),  32'(vt[n].hp));
      chk($sformatf("v%0d_lck", n),  32'(locked),       32'(vt[n].lck));
      chk($sformatf("v%0d_lost", n), 32'(clk_lost),     32'(vt[n].lost));
      chk($sformatf("v%0d_err", n),  32'(err_count),    32'(vt[n].err));
    end

    // Clock stops low while locked
    halfp(2);
    for (int i = 0; i < 40 && !clk_lost; i++) tick();
    chk("lost_set", 32'(clk_lost), 32'd1);
    chk("lost_latency", 32'(cyc - last_edge_cyc), 32'd17);
    chk("lost_unlock", 32'(locked), 32'd0);
    chk("lost_err", 32'(err_count), 32'd1);

    // Recovery: lost clears one cycle after the first edge, relock at the 5th
    e0 = n_edges;
    repeat (8) halfp(2);
    chk("rec_lost_edges", 32'(lost_fall_edges - e0), 32'd1);
    chk("rec_lost_dly", 32'(lost_fall_dly), 32'd1);
    chk("rec_lock_edges", 32'(lock_rise_edges - e0), 32'd5);
    chk("rec_lock_dly", 32'(lock_rise_dly), 32'd1);
    chk("rec_locked", 32'(locked), 32'd1);
    chk("rec_err", 32'(err_count), 32'd1);

    // One stretched half-period of 3 while locked
    halfp(3);
    repeat (6) halfp(2);
    chk("glitch_hp", 32'(bad_hp), 32'd3);
    chk("glitch_err", 32'(bad_err), 32'd2);
    chk("glitch_unlock_dly", 32'(unlock_dly), 32'd1);
    chk("glitch_relock_edges", 32'(lock_rise_edges - bad_edge), 32'd4);
    chk("glitch_relock_dly", 32'(lock_rise_dly), 32'd1);
    chk("glitch_locked", 32'(locked), 32'd1);

    // Asynchronous reset between clock edges while locked
    @(posedge system_clk);
    #3;
    reset  = 1'b1;
    clk_in = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(posedge system_clk);
    @(negedge system_clk);
    pv_cnt = 0;
    reset  = 1'b0;

    // No edges after reset: timeout from IDLE
    for (int n = 0; n < 17; n++) begin
      tick();
      if (n == 0)  chk("idle_lck", 32'(locked), 32'd0);
      if (n == 15) begin
        chk("idle_lost_early", 32'(clk_lost), 32'd0);
        chk("idle_err", 32'(err_count), 32'd1);
      end
      if (n == 16) chk("idle_lost", 32'(clk_lost), 32'd1);
    end
    chk("idle_no_pv", 32'(pv_cnt), 32'd0);

    // Alternating 3/2 half-periods: never locks, errors saturate
    lock_seen = 1'b0;
    wrap_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      halfp(3);
      halfp(2);
    end
    repeat (4) tick();
    chk("alt_never_locked", 32'(lock_seen), 32'd0);
    chk("alt_no_wrap", 32'(wrap_seen), 32'd0);
    chk("alt_err_sat", 32'(err_count), 32'd255);

    chk("strobe_exclusive", 32'(both_seen), 32'd0);
    chk("strobe_single", 32'(dbl_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
